// File: rtl/vga_sprite_renderer.sv
// 16x16 1-bpp sprite overlay on a solid background, 2-cycle pipeline with matched syncs.
// Optional SPRITE_SCALE2X_EN enables the 32x32 pixel-doubled window selected by control bit1.
module vga_sprite_renderer #(
   parameter int H_BITS = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              display_on_in,
   input  logic [H_BITS-1:0] hpos,
   input  logic [H_BITS-1:0] vpos,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [15:0]       wr_data,
   output logic [5:0]        rgb,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              frame_irq
);

   localparam logic [4:0] ADDR_X     = 5'h10;
   localparam logic [4:0] ADDR_Y     = 5'h11;
   localparam logic [4:0] ADDR_COL   = 5'h12;
   localparam logic [4:0] ADDR_CTRL  = 5'h13;
   localparam logic [4:0] ADDR_IRQCL = 5'h14;

   logic [15:0]       bitmap [16];
   logic [H_BITS-1:0] pend_x, pend_y, act_x, act_y;
   logic [5:0]        pend_fg, pend_bg, act_fg, act_bg;
   logic [1:0]        pend_ctrl, act_ctrl;
   logic              vsync_prev;
   logic              vs_rise;
   logic              irq_clear;

   assign vs_rise   = vsync_in & ~vsync_prev;
   assign irq_clear = wr_en && (wr_addr == ADDR_IRQCL) && wr_data[0];

   // Bitmap is live: no shadow copy, so writes land on the very next pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) bitmap[i] <= '0;
      end else if (wr_en && !wr_addr[4]) begin
         bitmap[wr_addr[3:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_x    <= '0;
         pend_y    <= '0;
         pend_fg   <= '0;
         pend_bg   <= '0;
         pend_ctrl <= '0;
      end else if (wr_en) begin
         case (wr_addr)
            ADDR_X:    pend_x <= wr_data[H_BITS-1:0];
            ADDR_Y:    pend_y <= wr_data[H_BITS-1:0];
            ADDR_COL: begin
               pend_fg <= wr_data[5:0];
               pend_bg <= wr_data[13:8];
            end
            ADDR_CTRL: pend_ctrl <= wr_data[1:0];
            default: ;
         endcase
      end
   end

   // All shadowed registers move together on the vsync rise so a frame never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_prev <= 1'b0;
         act_x      <= '0;
         act_y      <= '0;
         act_fg     <= '0;
         act_bg     <= '0;
         act_ctrl   <= '0;
         frame_irq  <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         if (vs_rise) begin
            act_x    <= pend_x;
            act_y    <= pend_y;
            act_fg   <= pend_fg;
            act_bg   <= pend_bg;
            act_ctrl <= pend_ctrl;
         end
         if (vs_rise)        frame_irq <= 1'b1;
         else if (irq_clear) frame_irq <= 1'b0;
      end
   end

   logic [H_BITS-1:0] dx, dy;
   logic              in_x, in_y, hit;
   logic [3:0]        col, row;

   assign dx = hpos - act_x;
   assign dy = vpos - act_y;

`ifdef SPRITE_SCALE2X_EN
   logic scale;
   assign scale = act_ctrl[1];
   assign in_x  = scale ? (dx < H_BITS'(32)) : (dx < H_BITS'(16));
   assign in_y  = scale ? (dy < H_BITS'(32)) : (dy < H_BITS'(16));
   assign col   = scale ? dx[4:1] : dx[3:0];
   assign row   = scale ? dy[4:1] : dy[3:0];
`else
   logic unused_scale;
   assign unused_scale = act_ctrl[1];
   assign in_x = (dx[H_BITS-1:4] == '0);
   assign in_y = (dy[H_BITS-1:4] == '0);
   assign col  = dx[3:0];
   assign row  = dy[3:0];
`endif

   assign hit = act_ctrl[0] & in_x & in_y;

   logic       s1_hit, s1_de, s1_hs, s1_vs;
   logic [3:0] s1_col, s1_row;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_hit <= 1'b0;
         s1_de  <= 1'b0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_col <= '0;
         s1_row <= '0;
      end else begin
         s1_hit <= hit;
         s1_de  <= display_on_in;
         s1_hs  <= hsync_in;
         s1_vs  <= vsync_in;
         s1_col <= col;
         s1_row <= row;
      end
   end

   // Bit 15 of a row is the leftmost pixel, so column 0 maps to bit 15.
   logic [15:0] row_bits;
   logic        pix_bit;
   assign row_bits = bitmap[s1_row];
   assign pix_bit  = row_bits[4'd15 - s1_col];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb       <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         hsync_out <= s1_hs;
         vsync_out <= s1_vs;
         if (!s1_de)                rgb <= '0;
         else if (s1_hit && pix_bit) rgb <= act_fg;
         else                       rgb <= act_bg;
      end
   end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed self-checking bench for vga_sprite_renderer (honours SPRITE_SCALE2X_EN for the scale case).
module tb_vga_sprite_renderer;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync_in, vsync_in, display_on_in;
   logic [9:0] hpos, vpos;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [15:0] wr_data;
   logic [5:0] rgb;
   logic       hsync_out, vsync_out, frame_irq;

   int checks = 0;
   int errors = 0;

   int         sh [8];
   int         sv [8];
   logic       sde [8];
   logic       shs [8];
   logic [5:0] cap_rgb [8];
   logic       cap_hs [8];

   vga_sprite_renderer #(.H_BITS(10)) dut (
      .clk(clk), .reset(reset),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on_in(display_on_in),
      .hpos(hpos), .vpos(vpos),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_irq(frame_irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int h, input int v, input logic de, input logic hs);
      hpos          = 10'(h);
      vpos          = 10'(v);
      display_on_in = de;
      hsync_in      = hs;
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic vsync_pulse();
      vsync_in = 1'b1;
      tick();
      tick();
      vsync_in = 1'b0;
      tick();
      tick();
   endtask

   task automatic pix(input int i, input int h, input int v, input logic de, input logic hs);
      sh[i] = h; sv[i] = v; sde[i] = de; shs[i] = hs;
   endtask

   // Drives one pixel per cycle; output for pixel i is captured two edges after it is driven.
   task automatic run_stream(input int n);
      for (int i = 0; i <= n; i++) begin
         if (i < n) drive(sh[i], sv[i], sde[i], shs[i]);
         else       drive(0, 0, 1'b0, 1'b0);
         tick();
         if (i >= 1) begin
            cap_rgb[i-1] = rgb;
            cap_hs[i-1]  = hsync_out;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hsync_in = 0; vsync_in = 0; display_on_in = 0; hpos = 0; vpos = 0;
      wr_en = 0; wr_addr = 0; wr_data = 0;
      #12;
      checks++;
      if ({rgb, hsync_out, vsync_out, frame_irq} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {rgb, hsync_out, vsync_out, frame_irq});
      end
      tick();
      reset = 1'b0;
      drive(10, 10, 1'b1, 1'b0);
      tick(); tick();
      checks++;
      if (rgb !== 6'h00) begin
         errors++;
         $display("FAIL reset_bg_black got %h want 00", rgb);
      end
   endtask

   task automatic test_basic_draw();
      logic [5:0] exp_rgb [8] = '{6'h03, 6'h3F, 6'h03, 6'h3F, 6'h03, 6'h03, 6'h03, 6'h00};
      wr(5'h00, 16'h8001);
      wr(5'h10, 16'd100);
      wr(5'h11, 16'd50);
      wr(5'h12, 16'h033F);
      wr(5'h13, 16'h0001);
      drive(100, 50, 1'b1, 1'b0);
      tick(); tick();
      checks++;
      if (rgb !== 6'h00) begin
         errors++;
         $display("FAIL basic_before_vsync got %h want 00", rgb);
      end
      vsync_in = 1'b1;
      tick();
      checks++;
      if (frame_irq !== 1'b1 || vsync_out !== 1'b0) begin
         errors++;
         $display("FAIL basic_vsync_edge irq=%b vso=%b want irq=1 vso=0", frame_irq, vsync_out);
      end
      tick();
      checks++;
      if (vsync_out !== 1'b1) begin
         errors++;
         $display("FAIL basic_vsync_delay got %b want 1", vsync_out);
      end
      vsync_in = 1'b0;
      tick(); tick();
      pix(0, 99, 50, 1, 0); pix(1, 100, 50, 1, 1); pix(2, 101, 50, 1, 0);
      pix(3, 115, 50, 1, 1); pix(4, 116, 50, 1, 0); pix(5, 100, 49, 1, 0);
      pix(6, 100, 51, 1, 1); pix(7, 100, 50, 0, 0);
      run_stream(8);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cap_rgb[i] !== exp_rgb[i] || cap_hs[i] !== shs[i]) begin
            errors++;
            $display("FAIL basic_px%0d rgb=%h hs=%b want rgb=%h hs=%b",
                     i, cap_rgb[i], cap_hs[i], exp_rgb[i], shs[i]);
         end
      end
   endtask

   task automatic test_shadow();
      wr(5'h14, 16'h0001);
      checks++;
      if (frame_irq !== 1'b0) begin
         errors++;
         $display("FAIL shadow_irq_clear got %b want 0", frame_irq);
      end
      wr(5'h10, 16'd200);
      pix(0, 100, 50, 1, 0); pix(1, 200, 50, 1, 0);
      run_stream(2);
      checks++;
      if (cap_rgb[0] !== 6'h3F || cap_rgb[1] !== 6'h03) begin
         errors++;
         $display("FAIL shadow_old_frame got %h %h want 3f 03", cap_rgb[0], cap_rgb[1]);
      end
      vsync_pulse();
      checks++;
      if (frame_irq !== 1'b1) begin
         errors++;
         $display("FAIL shadow_irq got %b want 1", frame_irq);
      end
      run_stream(2);
      checks++;
      if (cap_rgb[0] !== 6'h03 || cap_rgb[1] !== 6'h3F) begin
         errors++;
         $display("FAIL shadow_new_frame got %h %h want 03 3f", cap_rgb[0], cap_rgb[1]);
      end
      wr(5'h00, 16'h0000);
      pix(0, 200, 50, 1, 0);
      run_stream(1);
      checks++;
      if (cap_rgb[0] !== 6'h03) begin
         errors++;
         $display("FAIL bitmap_live got %h want 03", cap_rgb[0]);
      end
   endtask

   task automatic test_irq_race();
      wr(5'h14, 16'h0001);
      vsync_in = 1'b1;
      wr(5'h14, 16'h0001);
      checks++;
      if (frame_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_race got %b want 1", frame_irq);
      end
      wr(5'h14, 16'h0001);
      checks++;
      if (frame_irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_later_clear got %b want 0", frame_irq);
      end
      vsync_in = 1'b0;
      tick(); tick();
   endtask

   task automatic test_wrap();
      logic [5:0] exp_rgb [6] = '{6'h3F, 6'h3F, 6'h03, 6'h00, 6'h00, 6'h03};
      wr(5'h00, 16'hFFFF);
      wr(5'h10, 16'd1020);
      vsync_pulse();
      pix(0, 0, 50, 1, 0); pix(1, 11, 50, 1, 0); pix(2, 12, 50, 1, 0);
      pix(3, 1020, 50, 0, 0); pix(4, 1023, 50, 0, 0); pix(5, 4, 49, 1, 0);
      run_stream(6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_rgb[i] !== exp_rgb[i]) begin
            errors++;
            $display("FAIL wrap_px%0d got %h want %h", i, cap_rgb[i], exp_rgb[i]);
         end
      end
   endtask

   task automatic test_scale();
`ifdef SPRITE_SCALE2X_EN
      logic [5:0] exp_rgb [5] = '{6'h3F, 6'h3F, 6'h03, 6'h3F, 6'h03};
`else
      logic [5:0] exp_rgb [5] = '{6'h3F, 6'h03, 6'h03, 6'h03, 6'h03};
`endif
      wr(5'h13, 16'h0003);
      wr(5'h10, 16'd0);
      wr(5'h00, 16'h8000);
      vsync_pulse();
      pix(0, 0, 50, 1, 0); pix(1, 1, 50, 1, 0); pix(2, 2, 50, 1, 0);
      pix(3, 0, 51, 1, 0); pix(4, 0, 52, 1, 0);
      run_stream(5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_rgb[i] !== exp_rgb[i]) begin
            errors++;
            $display("FAIL scale_px%0d got %h want %h", i, cap_rgb[i], exp_rgb[i]);
         end
      end
   endtask

   task automatic test_reset_midline();
      drive(500, 50, 1'b1, 1'b1);
      tick(); tick(); tick();
      checks++;
      if (rgb !== 6'h03 || hsync_out !== 1'b1 || frame_irq !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre rgb=%h hs=%b irq=%b want 03 1 1", rgb, hsync_out, frame_irq);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({rgb, hsync_out, vsync_out, frame_irq} !== 9'd0) begin
         errors++;
         $display("FAIL midreset_async got %h want 0", {rgb, hsync_out, vsync_out, frame_irq});
      end
      tick();
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (rgb !== 6'h00 || hsync_out !== 1'b1 || frame_irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after rgb=%h hs=%b irq=%b want 00 1 0", rgb, hsync_out, frame_irq);
      end
   endtask

   initial begin
      test_reset();
      test_basic_draw();
      test_shadow();
      test_irq_race();
      test_wrap();
      test_scale();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
